// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one SDRAM controller port between a ROM-download write port and
// four read clients (CPU program ROM, tile ROM, sprite ROM, sound ROM).
// Requests are taken one at a time. The controller's ack/valid/q are
// routed back to whichever client holds the grant. New read grants are
// held off while a download is in progress.
//
// Optional feature macro: SDRAM_ARBITER_ROUND_ROBIN_EN
//   defined   : read clients are arbitrated round-robin. The search starts
//               at a pointer that moves past the last granted client.
//   undefined : fixed priority, client 0 highest. No pointer register.
//   The download port always has top priority, and download gating
//   applies in both builds.
//
// Ports
//   clk, reset             system clock; synchronous active-high reset
//   dl_req/addr/data       download write request (level, held to dl_ack)
//   dl_ack                 one-cycle pulse, write accepted by controller
//   download               download in progress, inhibits new read grants
//   rd_req[3:0]            per-client read requests (level, held to rd_ack)
//   rd_addr                packed client addresses, n at [n*AW +: AW]
//   rd_ack[3:0]            one-hot pulse, client request accepted
//   rd_valid[3:0]          one-hot pulse, rd_q holds that client's data
//   rd_q                   shared read data
//   sdram_*                controller request/response port
//
// States
//   S_IDLE | arbitrate pending requests, issue the winner next cycle
//   S_REQ  | sdram_req held with stable addr/data/we until sdram_ack
//   S_WAIT | read accepted, waiting for sdram_valid

module sdram_arbiter #(
  parameter int ADDR_WIDTH  = 23,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLIENTS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              dl_req,
  input  logic [ADDR_WIDTH-1:0]             dl_addr,
  input  logic [DATA_WIDTH-1:0]             dl_data,
  output logic                              dl_ack,
  input  logic                              download,
  input  logic [NUM_CLIENTS-1:0]            rd_req,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_CLIENTS-1:0]            rd_ack,
  output logic [NUM_CLIENTS-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]             rd_q,
  output logic [ADDR_WIDTH-1:0]             sdram_addr,
  output logic [DATA_WIDTH-1:0]             sdram_data,
  output logic                              sdram_we,
  output logic                              sdram_req,
  input  logic                              sdram_ack,
  input  logic                              sdram_valid,
  input  logic [DATA_WIDTH-1:0]             sdram_q
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam logic [NUM_CLIENTS-1:0] ONE_HOT0 = NUM_CLIENTS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    grant_dl_q, grant_dl_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic                    sdram_req_d, sdram_we_d, dl_ack_d;
  logic [ADDR_WIDTH-1:0]   sdram_addr_d;
  logic [DATA_WIDTH-1:0]   sdram_data_d, rd_q_d;
  logic [NUM_CLIENTS-1:0]  rd_ack_d, rd_valid_d;

  // A requester whose ack is on the output this cycle is still holding its
  // level request; mask it so it is not granted a second time.
  logic                    dl_pend;
  logic [NUM_CLIENTS-1:0]  rd_pend;
  logic                    rd_hit;
  logic [IDX_W-1:0]        rd_sel;

  assign dl_pend = dl_req & ~dl_ack;
  assign rd_pend = download ? '0 : (rd_req & ~rd_ack);

`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Scan downward so the client closest to the pointer wins. The index
  // wraps naturally because NUM_CLIENTS is a power of two.
  always_comb begin
    rd_hit = 1'b0;
    rd_sel = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (rd_pend[rr_ptr_q + IDX_W'(k)]) begin
        rd_hit = 1'b1;
        rd_sel = rr_ptr_q + IDX_W'(k);
      end
    end
  end
`else
  always_comb begin
    rd_hit = 1'b0;
    rd_sel = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (rd_pend[k]) begin
        rd_hit = 1'b1;
        rd_sel = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    grant_dl_d   = grant_dl_q;
    grant_d      = grant_q;
    sdram_req_d  = sdram_req;
    sdram_addr_d = sdram_addr;
    sdram_data_d = sdram_data;
    sdram_we_d   = sdram_we;
    dl_ack_d     = 1'b0;
    rd_ack_d     = '0;
    rd_valid_d   = '0;
    rd_q_d       = rd_q;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (dl_pend) begin
          grant_dl_d   = 1'b1;
          sdram_req_d  = 1'b1;
          sdram_addr_d = dl_addr;
          sdram_data_d = dl_data;
          sdram_we_d   = 1'b1;
          state_d      = S_REQ;
        end else if (rd_hit) begin
          grant_dl_d   = 1'b0;
          grant_d      = rd_sel;
          sdram_req_d  = 1'b1;
          sdram_addr_d = rd_addr[int'(rd_sel)*ADDR_WIDTH +: ADDR_WIDTH];
          sdram_data_d = '0;
          sdram_we_d   = 1'b0;
          state_d      = S_REQ;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
          rr_ptr_d     = rd_sel + IDX_W'(1);
`endif
        end
      end
      S_REQ: begin
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          if (grant_dl_q) begin
            dl_ack_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            rd_ack_d = ONE_HOT0 << grant_q;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (sdram_valid) begin
          rd_q_d     = sdram_q;
          rd_valid_d = ONE_HOT0 << grant_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_dl_q <= 1'b0;
      grant_q    <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_we   <= 1'b0;
      dl_ack     <= 1'b0;
      rd_ack     <= '0;
      rd_valid   <= '0;
      rd_q       <= '0;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_dl_q <= grant_dl_d;
      grant_q    <= grant_d;
      sdram_req  <= sdram_req_d;
      sdram_addr <= sdram_addr_d;
      sdram_data <= sdram_data_d;
      sdram_we   <= sdram_we_d;
      dl_ack     <= dl_ack_d;
      rd_ack     <= rd_ack_d;
      rd_valid   <= rd_valid_d;
      rd_q       <= rd_q_d;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  localparam int AW = 23;
  localparam int DW = 32;

`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [AW-1:0] DLA = 23'h000010;
  localparam logic [DW-1:0] DLD = 32'h11223344;
  localparam logic [AW-1:0] A0  = 23'h000100;
  localparam logic [AW-1:0] A1  = 23'h000200;
  localparam logic [AW-1:0] A2  = 23'h012340;
  localparam logic [AW-1:0] A3  = 23'h7FFFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          dl_req;
  logic [AW-1:0] dl_addr;
  logic [DW-1:0] dl_data;
  logic          dl_ack;
  logic          download;
  logic [3:0]    rd_req;
  logic [4*AW-1:0] rd_addr;
  logic [3:0]    rd_ack;
  logic [3:0]    rd_valid;
  logic [DW-1:0] rd_q;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_data;
  logic          sdram_we;
  logic          sdram_req;
  logic          sdram_ack;
  logic          sdram_valid;
  logic [DW-1:0] sdram_q;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CLIENTS(4)) dut (
    .clk(clk), .reset(reset),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
    .download(download),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_q(rd_q),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
    .sdram_q(sdram_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] cli_addr [4];

  typedef struct {
    logic          dl;
    logic          dn;
    logic [3:0]    rr;
    logic          ak;
    logic          vl;
    logic [DW-1:0] q;
    logic          e_req;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic          e_dl_ack;
    logic [3:0]    e_rd_ack;
    logic [3:0]    e_rd_valid;
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_cli(input int k, input logic [AW-1:0] a);
    cli_addr[k] = a;
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic setv(input int i, input logic dl, input logic dn, input logic [3:0] rr,
                      input logic ak, input logic vl, input logic [DW-1:0] q,
                      input logic er, input logic ew, input logic [AW-1:0] ea,
                      input logic eda, input logic [3:0] era, input logic [3:0] erv);
    tbl[i].dl = dl; tbl[i].dn = dn; tbl[i].rr = rr; tbl[i].ak = ak; tbl[i].vl = vl;
    tbl[i].q = q; tbl[i].e_req = er; tbl[i].e_we = ew; tbl[i].e_addr = ea;
    tbl[i].e_dl_ack = eda; tbl[i].e_rd_ack = era; tbl[i].e_rd_valid = erv;
  endtask

  function automatic logic [3:0] oh(input int n);
    return 4'b0001 << n;
  endfunction

  // Round-robin: first asserted bit at or after the pointer; fixed: pointer stays 0.
  function automatic int pick_rd(input logic [3:0] pend, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (pend[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [127:0] all_out();
    return 128'({sdram_req, sdram_we, sdram_addr, sdram_data, dl_ack, rd_ack, rd_valid, rd_q});
  endfunction

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (sdram_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // transaction-level reference model state for the random phase
  int            phase;          // 0 nothing outstanding, 1 request issued, 2 awaiting data
  bit            cur_dl, sched, sched_dl, prev_ack, prev_val;
  int            cur_n, sched_n, rr_ptr_m;
  logic [AW-1:0] cur_addr, sched_addr;
  logic [DW-1:0] cur_data, sched_data, prev_q;
  logic          e_req, e_dl_ack;
  logic [3:0]    e_rd_ack, e_rd_valid;

  initial begin
    bit ok;
    int got, n;

    reset = 1'b1; dl_req = 1'b0; dl_addr = DLA; dl_data = DLD; download = 1'b0;
    rd_req = 4'b0; rd_addr = '0; sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_q = '0;
    set_cli(0, A0); set_cli(1, A1); set_cli(2, A2); set_cli(3, A3);

    //    dl    dn    rd_req   ack   val   q              req   we    addr  dl_ack rd_ack   rd_valid
    setv(0,  1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, DLA, 1'b0, 4'b0000, 4'b0000);
    setv(1,  1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, DLA, 1'b0, 4'b0000, 4'b0000);
    setv(2,  1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, A0,  1'b1, 4'b0000, 4'b0000);
    setv(3,  1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, A0,  1'b0, 4'b0000, 4'b0000);
    setv(4,  1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, A0,  1'b0, 4'b0000, 4'b0000);
    setv(5,  1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, A0,  1'b0, 4'b0000, 4'b0000);
    setv(6,  1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, A0,  1'b0, 4'b0001, 4'b0000);
    setv(7,  1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 32'hCAFEF00D,  1'b0, 1'b0, A0,  1'b0, 4'b0000, 4'b0001);
    setv(8,  1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, A1,  1'b0, 4'b0000, 4'b0000);
    setv(9,  1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, A1,  1'b0, 4'b0010, 4'b0000);
    setv(10, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, A1,  1'b0, 4'b0000, 4'b0000);
    setv(11, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 32'h12345678,  1'b0, 1'b0, A1,  1'b0, 4'b0000, 4'b0010);
    setv(12, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, A3,  1'b0, 4'b0000, 4'b0000);
    setv(13, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 32'hBAD0BAD0,  1'b0, 1'b0, A3,  1'b0, 4'b1000, 4'b0000);
    setv(14, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0BADF00D,  1'b0, 1'b0, A3,  1'b0, 4'b0000, 4'b1000);
    setv(15, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 32'hFFFF0000,  1'b0, 1'b0, A3,  1'b0, 4'b0000, 4'b0000);
    setv(16, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 32'h0F0F0F0F,  1'b0, 1'b0, A3,  1'b0, 4'b0000, 4'b0000);

    tick(); tick();
    chk("reset_outputs", all_out(), 128'(0));
    reset = 1'b0;

    // table: write priority, download gating, fixed order 1 then 3, ignored valids
    for (int i = 0; i < 17; i++) begin
      dl_req = tbl[i].dl; download = tbl[i].dn; rd_req = tbl[i].rr;
      sdram_ack = tbl[i].ak; sdram_valid = tbl[i].vl; sdram_q = tbl[i].q;
      tick();
      chk($sformatf("vec%0d_ctl", i), 128'({sdram_req, dl_ack, rd_ack, rd_valid}),
          128'({tbl[i].e_req, tbl[i].e_dl_ack, tbl[i].e_rd_ack, tbl[i].e_rd_valid}));
      if (tbl[i].e_req)
        chk($sformatf("vec%0d_addr_we", i), 128'({sdram_we, sdram_addr}),
            128'({tbl[i].e_we, tbl[i].e_addr}));
      if (tbl[i].e_req && tbl[i].e_we)
        chk($sformatf("vec%0d_data", i), 128'(sdram_data), 128'(DLD));
      if (tbl[i].e_rd_valid != 4'b0000)
        chk($sformatf("vec%0d_rd_q", i), 128'(rd_q), 128'(tbl[i].q));
    end
    dl_req = 1'b0; rd_req = 4'b0; sdram_ack = 1'b0; sdram_valid = 1'b0;
    tick();

    // single read, ack after 3 cycles, valid 5 cycles later
    rd_req = 4'b0100;
    tick();
    chk("single_req", 128'({sdram_req, sdram_we, sdram_addr}), 128'({1'b1, 1'b0, A2}));
    tick(); tick();
    sdram_ack = 1'b1;
    tick();
    chk("single_ack", 128'({sdram_req, rd_ack}), 128'({1'b0, 4'b0100}));
    rd_req = 4'b0; sdram_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("single_quiet", 128'({rd_ack, rd_valid}), 128'(0));
    end
    sdram_valid = 1'b1; sdram_q = 32'hDEADBEEF;
    tick();
    chk("single_valid", 128'({rd_valid, rd_q}), 128'({4'b0100, 32'hDEADBEEF}));
    sdram_valid = 1'b0;
    tick();
    chk("single_pulse", 128'({rd_ack, rd_valid}), 128'(0));

    // stall: ack held low for 20 cycles
    rd_req = 4'b0001;
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("stall_hold", 128'({sdram_req, sdram_we, sdram_addr, sdram_data, rd_ack}),
          128'({1'b1, 1'b0, A0, 32'h0, 4'b0000}));
    end
    sdram_ack = 1'b1;
    tick();
    chk("stall_ack", 128'(rd_ack), 128'(4'b0001));
    rd_req = 4'b0; sdram_ack = 1'b0; sdram_valid = 1'b1; sdram_q = 32'h0;
    tick();
    sdram_valid = 1'b0;
    tick();

    // reset pulsed while waiting for read data, then a stray valid
    rd_req = 4'b0010;
    tick();
    sdram_ack = 1'b1;
    tick();
    rd_req = 4'b0; sdram_ack = 1'b0; reset = 1'b1;
    tick();
    chk("midreset_outputs", all_out(), 128'(0));
    reset = 1'b0; sdram_valid = 1'b1; sdram_q = 32'h55AA55AA;
    tick();
    chk("midreset_stray", all_out(), 128'(0));
    sdram_valid = 1'b0; rd_req = 4'b1000;
    tick();
    chk("after_reset_req", 128'({sdram_req, sdram_we, sdram_addr}), 128'({1'b1, 1'b0, A3}));
    sdram_ack = 1'b1;
    tick();
    chk("after_reset_ack", 128'(rd_ack), 128'(4'b1000));
    rd_req = 4'b0; sdram_ack = 1'b0; sdram_valid = 1'b1; sdram_q = 32'h0ABC0DEF;
    tick();
    chk("after_reset_valid", 128'({rd_valid, rd_q}), 128'({4'b1000, 32'h0ABC0DEF}));
    sdram_valid = 1'b0;
    tick();

    // all clients held requesting: round-robin 0,1,2,3,0 or fixed 0,0,0,0,0
    rd_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_req(10, ok);
      if (!ok) begin
        checks++; failures++;
        $display("FAIL order_timeout grant=%0d actual=no_request required=request", g);
        break;
      end
      got = -1;
      for (int k = 0; k < 4; k++) if (sdram_addr == cli_addr[k]) got = k;
      chk($sformatf("order_grant%0d", g), 128'(got), 128'(RR ? g % 4 : 0));
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0; sdram_valid = 1'b1;
      tick();
      sdram_valid = 1'b0;
    end
    rd_req = 4'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; download = 1'b0;

    // randomized traffic against the transaction model
    phase = 0; sched = 1'b0; prev_ack = 1'b0; prev_val = 1'b0; rr_ptr_m = 0;
    cur_dl = 1'b0; cur_n = 0; cur_addr = '0; cur_data = '0; prev_q = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      e_dl_ack   = prev_ack && cur_dl;
      e_rd_ack   = (prev_ack && !cur_dl) ? oh(cur_n) : 4'b0000;
      e_rd_valid = prev_val ? oh(cur_n) : 4'b0000;
      e_req      = sched || (phase == 1 && !prev_ack);
      if (sched) begin
        cur_dl = sched_dl; cur_n = sched_n; cur_addr = sched_addr; cur_data = sched_data;
      end
      chk("rnd_ctl", 128'({sdram_req, dl_ack, rd_ack, rd_valid}),
          128'({e_req, e_dl_ack, e_rd_ack, e_rd_valid}));
      if (e_req) chk("rnd_addr_we", 128'({sdram_we, sdram_addr}), 128'({cur_dl, cur_addr}));
      if (e_req && cur_dl) chk("rnd_data", 128'(sdram_data), 128'(cur_data));
      if (prev_val) chk("rnd_rd_q", 128'(rd_q), 128'(prev_q));

      if (prev_ack) phase = cur_dl ? 0 : 2;
      if (prev_val) phase = 0;
      if (sched) phase = 1;
      prev_ack = 1'b0; prev_val = 1'b0; sched = 1'b0;

      if (e_dl_ack) dl_req = 1'b0;
      rd_req = rd_req & ~e_rd_ack;
      if (!dl_req && !e_dl_ack && $urandom_range(0, 9) == 0) begin
        dl_req = 1'b1; dl_addr = AW'($urandom); dl_data = $urandom;
      end
      for (int k = 0; k < 4; k++) begin
        if (!rd_req[k] && !e_rd_ack[k] && $urandom_range(0, 5) == 0) begin
          set_cli(k, AW'($urandom));
          rd_req[k] = 1'b1;
        end
      end
      if ($urandom_range(0, 29) == 0) download = ~download;

      sdram_ack = (phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      prev_ack = (phase == 1) && sdram_ack;
      sdram_valid = (phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      sdram_q = $urandom;
      prev_val = (phase == 2) && sdram_valid;
      prev_q = sdram_q;

      if (phase == 0) begin
        if (dl_req) begin
          sched = 1'b1; sched_dl = 1'b1; sched_n = 0;
          sched_addr = dl_addr; sched_data = dl_data;
        end else if (!download && rd_req != 4'b0000) begin
          n = pick_rd(rd_req, rr_ptr_m);
          sched = 1'b1; sched_dl = 1'b0; sched_n = n;
          sched_addr = cli_addr[n]; sched_data = '0;
          if (RR) rr_ptr_m = (n + 1) % 4;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
